// File: rtl/script_executor.sv
// Autonomous script runner: fetches 16-bit instructions from script memory, drives the
// UART transmit side and branches/waits on synchronised game feedback flags.
module script_executor #(
  parameter int FETCH_LAT   = 1,
  parameter int TICK_CYCLES = 9600
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        script_mode,
  input  logic [15:0] script,
  input  logic [3:0]  feedback,
  input  logic        tx_done,
  output logic [7:0]  pc,
  output logic [7:0]  tx_bits,
  output logic        tx_active,
  output logic        busy,
  output logic        done,
  output logic        error
);

  // state     | meaning
  // ----------+--------------------------------------------------------------
  // IDLE      | waiting for a rising edge of enable with script_mode low
  // FETCH     | waiting out the memory latency, then latching the word into ir
  // EXEC      | decoding ir and acting on it
  // SEND_WAIT | tx_bits owned by the executor until tx_done
  // FB_WAIT   | waiting for fb_s[sel] == pol
  // DELAY     | counting down arg*TICK_CYCLES cycles
  // DONE      | END reached; held until abort
  // ERROR     | illegal opcode; held until abort

  localparam int         CNT_W      = $clog2(255 * TICK_CYCLES + 1);
  localparam logic [1:0] FETCH_WAIT = 2'(FETCH_LAT);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_SEND_WAIT, S_FB_WAIT, S_DELAY, S_DONE, S_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       pc_q, pc_d;
  logic [7:0]       tx_bits_q, tx_bits_d;
  logic             tx_active_q, tx_active_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [15:0]      ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       fcnt_q, fcnt_d;
  logic [3:0]       fb_meta_q, fb_s_q;
  logic             en_prev_q;

  logic       abort, start, cond_hit;
  logic [3:0] op;
  logic [7:0] arg, pc_inc;
  logic       unused_ir;

  assign op        = ir_q[15:12];
  assign arg       = ir_q[7:0];
  assign pc_inc    = pc_q + 8'd1;
  assign cond_hit  = (fb_s_q[ir_q[9:8]] == ir_q[11]);
  assign abort     = ~enable | script_mode;
  assign start     = enable & ~en_prev_q & ~script_mode;
  assign unused_ir = ir_q[10];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tx_bits_d   = tx_bits_q;
    tx_active_d = tx_active_q;
    done_d      = done_q;
    error_d     = error_q;
    ir_d        = ir_q;
    cnt_d       = cnt_q;
    fcnt_d      = fcnt_q;

    // Abort outranks tx_done and condition matches in the same cycle.
    if (state_q != S_IDLE && abort) begin
      state_d     = S_IDLE;
      pc_d        = 8'd0;
      tx_active_d = 1'b0;
      done_d      = 1'b0;
      error_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_FETCH;
            pc_d    = 8'd0;
          end
        end
        S_FETCH: begin
          if (fcnt_q == 2'd0) begin
            ir_d    = script;
            state_d = S_EXEC;
          end else begin
            fcnt_d = fcnt_q - 2'd1;
          end
        end
        S_EXEC: begin
          case (op)
            4'h0: begin
              pc_d    = pc_inc;
              state_d = S_FETCH;
            end
            4'h1: begin
              tx_bits_d   = arg;
              tx_active_d = 1'b1;
              state_d     = S_SEND_WAIT;
            end
            4'h2: state_d = S_FB_WAIT;
            4'h3: begin
              if (arg == 8'd0) begin
                pc_d    = pc_inc;
                state_d = S_FETCH;
              end else begin
                cnt_d   = CNT_W'(32'(arg) * 32'(TICK_CYCLES) - 32'd1);
                state_d = S_DELAY;
              end
            end
            4'h4: begin
              pc_d    = arg;
              state_d = S_FETCH;
            end
            4'h5: begin
              pc_d    = cond_hit ? arg : pc_inc;
              state_d = S_FETCH;
            end
            4'hF: begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end
            default: begin
              error_d = 1'b1;
              state_d = S_ERROR;
            end
          endcase
        end
        S_SEND_WAIT: begin
          if (tx_done) begin
            tx_active_d = 1'b0;
            pc_d        = pc_inc;
            state_d     = S_FETCH;
          end
        end
        S_FB_WAIT: begin
          if (cond_hit) begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end
        end
        S_DELAY: begin
          if (cnt_q == '0) begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Every pc write restarts the fetch latency count.
    if (state_d == S_FETCH && state_q != S_FETCH) fcnt_d = FETCH_WAIT;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pc_q        <= 8'd0;
      tx_bits_q   <= 8'h00;
      tx_active_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      ir_q        <= 16'h0000;
      cnt_q       <= '0;
      fcnt_q      <= 2'd0;
      fb_meta_q   <= 4'h0;
      fb_s_q      <= 4'h0;
      // Preset high so an enable already asserted at reset release is not a start.
      en_prev_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      tx_bits_q   <= tx_bits_d;
      tx_active_q <= tx_active_d;
      done_q      <= done_d;
      error_q     <= error_d;
      ir_q        <= ir_d;
      cnt_q       <= cnt_d;
      fcnt_q      <= fcnt_d;
      fb_meta_q   <= feedback;
      fb_s_q      <= fb_meta_q;
      en_prev_q   <= enable;
    end
  end

  assign pc        = pc_q;
  assign tx_bits   = tx_bits_q;
  assign tx_active = tx_active_q;
  assign done      = done_q;
  assign error     = error_q;
  assign busy      = !(state_q inside {S_IDLE, S_DONE, S_ERROR});

endmodule

// File: tb/tb_script_executor.sv
// Bench for script_executor: directed scripts with literal timing checks plus an
// instruction-level interpreter that predicts transmitted bytes and the final pc/flags.
module tb_script_executor;

  localparam int FL = 1;
  localparam int TK = 4;

  logic        clock = 1'b0;
  logic        reset, enable, script_mode;
  logic [15:0] script;
  logic [3:0]  feedback;
  logic        tx_done, tx_done_man, tx_done_auto, auto_on;
  logic [7:0]  pc, tx_bits;
  logic        tx_active, busy, done, error;

  logic [15:0] mem [0:255];
  logic [7:0]  exp_q [$];
  logic [7:0]  m_pc;
  logic        m_done, m_err, m_hang;
  logic        txa_prev;
  int          acnt;
  int          n_tests = 0;
  int          n_fail  = 0;

  assign tx_done = tx_done_man | tx_done_auto;

  always #5 clock = ~clock;

  // Script memory with one cycle of read latency (FETCH_LAT = 1).
  always @(posedge clock) script <= mem[pc];

  script_executor #(.FETCH_LAT(FL), .TICK_CYCLES(TK)) dut (
    .clock(clock), .reset(reset), .enable(enable), .script_mode(script_mode),
    .script(script), .feedback(feedback), .tx_done(tx_done),
    .pc(pc), .tx_bits(tx_bits), .tx_active(tx_active), .busy(busy),
    .done(done), .error(error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
  endtask

  // Instruction-level interpreter with constant feedback; no notion of cycles.
  task automatic model_run(input logic [3:0] fb);
    logic [7:0]  p;
    logic [15:0] w;
    p = 8'd0;
    exp_q.delete();
    m_done = 1'b0;
    m_err  = 1'b0;
    m_hang = 1'b1;
    for (int step = 0; step < 1000; step++) begin
      w = mem[p];
      case (w[15:12])
        4'h0, 4'h3: p = p + 8'd1;
        4'h1: begin
          exp_q.push_back(w[7:0]);
          p = p + 8'd1;
        end
        4'h2: begin
          if (fb[w[9:8]] == w[11]) p = p + 8'd1;
          else break;
        end
        4'h4: p = w[7:0];
        4'h5: p = (fb[w[9:8]] == w[11]) ? w[7:0] : p + 8'd1;
        4'hF: begin
          m_done = 1'b1;
          m_hang = 1'b0;
          break;
        end
        default: begin
          m_err  = 1'b1;
          m_hang = 1'b0;
          break;
        end
      endcase
    end
    m_pc = p;
  endtask

  task automatic wait_end(input int budget, input string name);
    int k = 0;
    while (!(done || error) && k < budget) begin
      cyc();
      k++;
    end
    if (!(done || error)) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no done/error within %0d cycles (pc=0x%0h)", name, budget, pc);
    end
  endtask

  task automatic wait_pc(input logic [7:0] target, input int budget, input string name);
    int k = 0;
    while (pc !== target && k < budget) begin
      cyc();
      k++;
    end
    check(name, pc, target);
  endtask

  task automatic wait_tx(input int budget, input string name);
    int k = 0;
    while (tx_active !== 1'b1 && k < budget) begin
      cyc();
      k++;
    end
    check(name, tx_active, 1);
  endtask

  task automatic run_script(input logic [3:0] fb, input string name);
    model_run(fb);
    feedback = fb;
    auto_on  = 1'b1;
    cyc(3);
    enable = 1'b1;
    wait_end(400, name);
    check({name, "_pc"}, pc, m_pc);
    check({name, "_done"}, done, m_done);
    check({name, "_error"}, error, m_err);
    check({name, "_busy"}, busy, 0);
    check({name, "_bytes_left"}, exp_q.size(), 0);
    enable = 1'b0;
    cyc();
    auto_on = 1'b0;
  endtask

  // Automatic UART responder: acknowledges a held byte after a few cycles.
  initial begin
    tx_done_auto = 1'b0;
    acnt = 0;
    forever begin
      @(negedge clock);
      if (tx_done_auto) tx_done_auto = 1'b0;
      else if (auto_on && tx_active) begin
        if (acnt == 3) begin
          tx_done_auto = 1'b1;
          acnt = 0;
        end else acnt++;
      end else acnt = 0;
    end
  end

  // Per-cycle compare against the model's byte stream and output invariants.
  initial begin
    txa_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (reset === 1'b1) begin
        check("done_with_error", done & error, 0);
        if (tx_active) check("tx_active_busy", busy, 1);
        if (tx_active && !txa_prev) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL tx_byte: got 0x%0h, expected no byte", tx_bits);
          end else check("tx_byte", tx_bits, exp_q.pop_front());
        end
        txa_prev = tx_active;
      end else txa_prev = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; enable = 1'b1; script_mode = 1'b0; feedback = 4'h0;
    tx_done_man = 1'b0; auto_on = 1'b0;
    clear_mem();
    cyc(3);
    check("rst_pc", pc, 0);
    check("rst_tx_bits", tx_bits, 0);
    check("rst_tx_active", tx_active, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    reset = 1'b1;
    cyc(5);
    check("no_start_without_edge", busy, 0);
    enable = 1'b0;
    cyc();

    // SEND 0x25, END with a manually timed tx_done.
    mem[0] = 16'h1025; mem[1] = 16'hF000;
    model_run(4'h0);
    check("model_send_pc", m_pc, 1);
    check("model_send_len", exp_q.size(), 1);
    enable = 1'b1;
    cyc(3);
    check("send_not_yet", tx_active, 0);
    cyc();
    check("send_active", tx_active, 1);
    check("send_bits", tx_bits, 8'h25);
    cyc(19);
    check("send_held", tx_active, 1);
    check("send_pc_held", pc, 0);
    tx_done_man = 1'b1;
    cyc();
    tx_done_man = 1'b0;
    check("send_released", tx_active, 0);
    check("send_pc_next", pc, 1);
    check("send_bits_kept", tx_bits, 8'h25);
    wait_end(20, "send_end");
    check("send_done", done, 1);
    check("send_busy", busy, 0);
    cyc(5);
    check("done_pc_frozen", pc, 1);
    enable = 1'b0;
    cyc();
    check("abort_clears_done", done, 0);
    check("abort_pc", pc, 0);

    // WAITFB sel=0 pol=1; feedback arrives after 100 cycles.
    clear_mem();
    mem[0] = 16'h2800; mem[1] = 16'h1011; mem[2] = 16'hF000;
    model_run(4'h1);
    check("model_waitfb_pc", m_pc, 2);
    auto_on = 1'b1;
    enable = 1'b1;
    cyc(100);
    check("waitfb_pc_stays", pc, 0);
    check("waitfb_busy", busy, 1);
    check("waitfb_no_tx", tx_active, 0);
    feedback = 4'h1;
    // 2 sync + 1 wait decision + (FETCH_LAT+1) fetch + 1 exec = 6 edges.
    cyc(5);
    check("waitfb_send_not_yet", tx_active, 0);
    cyc();
    check("waitfb_send_issued", tx_active, 1);
    check("waitfb_send_bits", tx_bits, 8'h11);
    wait_end(30, "waitfb_end");
    check("waitfb_done_pc", pc, 2);
    enable = 1'b0; feedback = 4'h0; auto_on = 1'b0;
    cyc();

    // DELAY 3 with TICK_CYCLES=4: 12 cycles in DELAY; stray tx_done ignored.
    clear_mem();
    mem[0] = 16'h3003;
    enable = 1'b1;
    cyc(6);
    tx_done_man = 1'b1;
    cyc();
    tx_done_man = 1'b0;
    cyc(8);
    check("delay_pc_before", pc, 0);
    cyc();
    check("delay_pc_after", pc, 1);
    wait_end(10, "delay_end");
    check("delay_done", done, 1);
    enable = 1'b0;
    cyc();

    mem[0] = 16'h3000;
    enable = 1'b1;
    cyc(3);
    check("delay0_pc_before", pc, 0);
    cyc();
    check("delay0_pc_after", pc, 1);
    wait_end(10, "delay0_end");
    enable = 1'b0;
    cyc();

    // JIF sel=2 pol=0 -> 0x05.
    clear_mem();
    mem[0] = 16'h5205;
    model_run(4'b0000);
    check("model_jif_taken", m_pc, 5);
    run_script(4'b0000, "jif_taken");
    model_run(4'b0100);
    check("model_jif_not_taken", m_pc, 1);
    run_script(4'b0100, "jif_not_taken");

    // Mixed script exercising every legal opcode.
    clear_mem();
    mem[0] = 16'h1001; mem[1] = 16'h0000; mem[2] = 16'h5906;
    mem[3] = 16'h1002; mem[4] = 16'hF000; mem[6] = 16'h1003;
    mem[7] = 16'h3002; mem[8] = 16'h2300; mem[9] = 16'h1004;
    mem[10] = 16'hF000;
    model_run(4'b0010);
    check("model_mix_pc", m_pc, 10);
    check("model_mix_len", exp_q.size(), 3);
    run_script(4'b0010, "mix_branch");
    run_script(4'b0000, "mix_fallthrough");
    mem[9] = 16'hA004;
    model_run(4'b0010);
    check("model_mix_err", m_err, 1);
    run_script(4'b0010, "mix_illegal");
    feedback = 4'h0;

    // JMP 0xFF then NOP at 255 wraps pc to 0.
    clear_mem();
    mem[0] = 16'h40FF; mem[255] = 16'h0000;
    model_run(4'h0);
    enable = 1'b1;
    wait_pc(8'hFF, 20, "jmp_ff");
    for (int k = 0; k < 10 && pc == 8'hFF; k++) cyc();
    check("pc_wrap", pc, 0);
    check("pc_wrap_error", error, 0);
    enable = 1'b0;
    cyc();
    check("jmp_abort_busy", busy, 0);

    // Illegal opcode 0x7, script_mode abort, re-run needs an enable edge.
    clear_mem();
    mem[0] = 16'h0000; mem[1] = 16'h7000;
    model_run(4'h0);
    enable = 1'b1;
    wait_end(20, "illegal_end");
    check("illegal_error", error, 1);
    check("illegal_busy", busy, 0);
    check("illegal_done", done, 0);
    cyc(10);
    check("error_pc_frozen", pc, 1);
    check("error_held", error, 1);
    script_mode = 1'b1;
    cyc();
    script_mode = 1'b0;
    check("smode_error_clr", error, 0);
    check("smode_pc", pc, 0);
    check("smode_busy", busy, 0);
    cyc(10);
    check("no_rerun_without_edge", busy, 0);
    enable = 1'b0;
    cyc();
    enable = 1'b1;
    cyc();
    check("rerun_on_edge", busy, 1);
    wait_end(20, "rerun_end");
    enable = 1'b0;
    cyc();

    // Abort coincident with tx_done during SEND_WAIT.
    clear_mem();
    mem[0] = 16'h105A;
    model_run(4'h0);
    enable = 1'b1;
    wait_tx(10, "abort_send_start");
    enable = 1'b0;
    tx_done_man = 1'b1;
    cyc();
    tx_done_man = 1'b0;
    check("abort_tx_pc", pc, 0);
    check("abort_tx_active", tx_active, 0);
    check("abort_tx_busy", busy, 0);
    check("abort_tx_bits", tx_bits, 8'h5A);
    cyc(3);
    check("abort_stays_idle", busy, 0);

    // Asynchronous reset in the middle of a long DELAY.
    clear_mem();
    mem[0] = 16'h1033; mem[1] = 16'h30C8;
    model_run(4'h0);
    auto_on = 1'b1;
    enable = 1'b1;
    wait_pc(8'd1, 40, "rst_delay_pc");
    cyc(10);
    check("rst_delay_busy", busy, 1);
    check("rst_delay_bits", tx_bits, 8'h33);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_pc", pc, 0);
    check("async_rst_tx_bits", tx_bits, 0);
    check("async_rst_tx_active", tx_active, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_error", error, 0);
    cyc();
    reset = 1'b1;
    enable = 1'b0;
    auto_on = 1'b0;
    cyc(3);
    check("post_rst_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
